// File: rtl/io_handshake_peer_pkg.sv
// Shared definitions for the I/O handshake peer.
//   state_t    : FSM state encodings (IDLE / WAIT / ACK), 2 bits
//   IO_DIR_RD  : io_rd value for a processor read (IN)
//   IO_DIR_WR  : io_rd value for a processor write (OUT)
package io_handshake_peer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic IO_DIR_RD = 1'b1;
  localparam logic IO_DIR_WR = 1'b0;

endpackage

// File: rtl/io_handshake_peer_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output.
// Ports:
//   clk, clr        : clock, asynchronous active-high clear
//   wr, wdata       : push request and data (dropped while full)
//   rd              : pop request (ignored while empty)
//   rdata           : current head entry
//   full, empty     : occupancy flags
//   count           : occupancy, a_width+1 bits so full and empty differ
module sync_fifo #(
  parameter int width   = 8,
  parameter int depth   = 4,
  parameter int a_width = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               wr,
  input  logic [width-1:0]   wdata,
  input  logic               rd,
  output logic [width-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [a_width:0]   count
);

  logic [width-1:0] mem_q [depth];
  logic [a_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [a_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [a_width:0]   count_q, count_d;
  logic               do_wr, do_rd;

  assign full  = (count_q == (a_width+1)'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  // Pointers are a_width bits wide, so wrap modulo depth falls out naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + a_width'(do_wr);
    rd_ptr_d = rd_ptr_q + a_width'(do_rd);
    count_d  = count_q + (a_width+1)'(do_wr) - (a_width+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty/count gate every observable use.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_handshake_peer.sv
// External-side responder for the processor's four-phase I/O handshake.
// Processor writes (io_rd=0) push bus_out into the RX FIFO; processor reads
// (io_rd=1) pop the host-filled TX FIFO onto bus_in.
// Ports:
//   g_clk, g_clr        : clock, asynchronous active-high reset
//   hs_out, hs_in       : processor request / our acknowledge
//   io_rd               : direction, latched when a request is accepted
//   bus_out, bus_in     : processor data out / data presented to the processor
//   tx_data, tx_wr      : host push into TX FIFO; tx_full flag, tx_ovf sticky overflow
//   rx_data, rx_rd      : RX FIFO head and pop; rx_empty, rx_count status
//   dbg_state           : current FSM state
// Handshake: a request is hs_out held high; hs_in rises once the transfer is
// done and stays high until hs_out is seen low, after which hs_in falls.
module io_handshake_peer
  import io_handshake_peer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int ACK_DELAY = 0
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              hs_out,
  input  logic              io_rd,
  input  logic [7:0]        bus_out,
  output logic [7:0]        bus_in,
  output logic              hs_in,
  input  logic [7:0]        tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic [7:0]        rx_data,
  input  logic              rx_rd,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_count,
  output logic              tx_ovf,
  output logic [1:0]        dbg_state
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [7:0]  bus_in_q, bus_in_d;
  logic        hs_in_q, hs_in_d;
  logic        tx_ovf_q, tx_ovf_d;

  logic        tx_pop, rx_push;
  logic [7:0]  tx_head;
  logic        tx_empty, rx_full;
  logic        fifo_ready;
  logic [ADDR_W:0] tx_count_unused;

  sync_fifo #(.width(8), .depth(DEPTH), .a_width(ADDR_W)) u_tx_fifo (
    .clk   (g_clk),
    .clr   (g_clr),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

  sync_fifo #(.width(8), .depth(DEPTH), .a_width(ADDR_W)) u_rx_fifo (
    .clk   (g_clk),
    .clr   (g_clr),
    .wr    (rx_push),
    .wdata (bus_out),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // The resource the latched direction needs: data to send or room to store.
  assign fifo_ready = (dir_q == IO_DIR_RD) ? ~tx_empty : ~rx_full;

  // State register
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_q    <= IO_DIR_WR;
      bus_in_q <= 8'h00;
      hs_in_q  <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      bus_in_q <= bus_in_d;
      hs_in_q  <= hs_in_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs_out) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!hs_out)                           state_d = ST_IDLE;
        else if (cnt_q == '0 && fifo_ready)    state_d = ST_ACK;
      end
      ST_ACK:  if (!hs_out) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    bus_in_d = bus_in_q;
    hs_in_d  = hs_in_q;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs_out) begin
          dir_d = io_rd;
          cnt_d = 4'(ACK_DELAY);
        end
      end
      ST_WAIT: begin
        // A dropped request aborts before any FIFO is touched.
        if (hs_out) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (fifo_ready) begin
            hs_in_d = 1'b1;
            if (dir_q == IO_DIR_RD) begin
              tx_pop   = 1'b1;
              bus_in_d = tx_head;
            end else begin
              rx_push  = 1'b1;
            end
          end
        end
      end
      ST_ACK: if (!hs_out) hs_in_d = 1'b0;
      default: ;
    endcase
  end

  // Overflow is sticky; a write while full is dropped inside the FIFO.
  assign tx_ovf_d = tx_ovf_q | (tx_wr & tx_full);

  assign bus_in    = bus_in_q;
  assign hs_in     = hs_in_q;
  assign tx_ovf    = tx_ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_io_handshake_peer.sv
module tb_io_handshake_peer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // ---------------- clock / reset ----------------
  logic g_clk = 1'b0;
  logic g_clr = 1'b1;
  always #5 g_clk = ~g_clk;

  int checks   = 0;
  int failures = 0;

  // DUT with ACK_DELAY=0
  logic       hs_out = 0, io_rd = 0, tx_wr = 0, rx_rd = 0;
  logic [7:0] bus_out = 0, tx_data = 0;
  logic [7:0] bus_in, rx_data;
  logic       hs_in, tx_full, rx_empty, tx_ovf;
  logic [2:0] rx_count;
  logic [1:0] dbg_state;

  io_handshake_peer #(.DEPTH(4), .ADDR_W(2), .ACK_DELAY(0)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .hs_out(hs_out), .io_rd(io_rd),
    .bus_out(bus_out), .bus_in(bus_in), .hs_in(hs_in),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_count(rx_count), .tx_ovf(tx_ovf), .dbg_state(dbg_state)
  );

  // DUT with ACK_DELAY=3
  logic       d3_hs_out = 0, d3_io_rd = 0, d3_tx_wr = 0, d3_rx_rd = 0;
  logic [7:0] d3_bus_out = 0, d3_tx_data = 0;
  logic [7:0] d3_bus_in, d3_rx_data;
  logic       d3_hs_in, d3_tx_full, d3_rx_empty, d3_tx_ovf;
  logic [2:0] d3_rx_count;
  logic [1:0] d3_dbg_state;

  io_handshake_peer #(.DEPTH(4), .ADDR_W(2), .ACK_DELAY(3)) dut3 (
    .g_clk(g_clk), .g_clr(g_clr), .hs_out(d3_hs_out), .io_rd(d3_io_rd),
    .bus_out(d3_bus_out), .bus_in(d3_bus_in), .hs_in(d3_hs_in),
    .tx_data(d3_tx_data), .tx_wr(d3_tx_wr), .tx_full(d3_tx_full),
    .rx_data(d3_rx_data), .rx_rd(d3_rx_rd), .rx_empty(d3_rx_empty),
    .rx_count(d3_rx_count), .tx_ovf(d3_tx_ovf), .dbg_state(d3_dbg_state)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge g_clk);
  endtask

  // ---------------- driver tasks ----------------
  // Full write handshake on dut; checks acknowledge timing.
  task automatic do_write(input logic [7:0] b);
    io_rd = 0; bus_out = b; hs_out = 1;
    step(); step();
    checks++;
    if (hs_in !== 1'b1) begin
      failures++; $display("FAIL write_ack[%0h] got=%0b exp=1", b, hs_in);
    end
    hs_out = 0;
    step();
    checks++;
    if (hs_in !== 1'b0) begin
      failures++; $display("FAIL write_release[%0h] got=%0b exp=0", b, hs_in);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b; tx_wr = 1;
    step();
    tx_wr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    g_clr = 1;
    step(); step();
    checks++; if (hs_in !== 1'b0) begin failures++; $display("FAIL reset_hs_in got=%0b exp=0", hs_in); end
    checks++; if (bus_in !== 8'h00) begin failures++; $display("FAIL reset_bus_in got=%0h exp=00", bus_in); end
    checks++; if (rx_empty !== 1'b1 || rx_count !== 3'd0) begin failures++; $display("FAIL reset_rx got empty=%0b count=%0d exp empty=1 count=0", rx_empty, rx_count); end
    checks++; if (tx_full !== 1'b0 || tx_ovf !== 1'b0) begin failures++; $display("FAIL reset_tx got full=%0b ovf=%0b exp 0 0", tx_full, tx_ovf); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (d3_hs_in !== 1'b0 || d3_rx_count !== 3'd0) begin failures++; $display("FAIL reset_dut3 got hs_in=%0b count=%0d exp 0 0", d3_hs_in, d3_rx_count); end
    g_clr = 0;
    step();
  endtask

  task automatic test_write();
    io_rd = 0; bus_out = 8'hA5; hs_out = 1;
    step();
    checks++; if (hs_in !== 1'b0 || dbg_state !== S_WAIT) begin failures++; $display("FAIL write_wait got hs_in=%0b state=%0d exp 0 %0d", hs_in, dbg_state, S_WAIT); end
    step();
    checks++; if (hs_in !== 1'b1) begin failures++; $display("FAIL write_hs_rise got=%0b exp=1", hs_in); end
    checks++; if (rx_empty !== 1'b0 || rx_data !== 8'hA5 || rx_count !== 3'd1) begin failures++; $display("FAIL write_rx got empty=%0b data=%0h count=%0d exp 0 a5 1", rx_empty, rx_data, rx_count); end
    checks++; if (bus_in !== 8'h00) begin failures++; $display("FAIL write_bus_in_hold got=%0h exp=00", bus_in); end
    hs_out = 0;
    step();
    checks++; if (hs_in !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL write_hs_fall got hs_in=%0b state=%0d exp 0 0", hs_in, dbg_state); end
    rx_rd = 1;
    step();
    rx_rd = 0;
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL write_drain got empty=%0b exp=1", rx_empty); end
  endtask

  task automatic test_read_stall();
    int low_cnt = 0;
    io_rd = 1; hs_out = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hs_in === 1'b0) low_cnt++;
    end
    checks++; if (low_cnt != 10) begin failures++; $display("FAIL stall_hs_low got=%0d cycles exp=10", low_cnt); end
    push_tx(8'h3C);
    step();
    checks++; if (hs_in !== 1'b1 || bus_in !== 8'h3C) begin failures++; $display("FAIL stall_release got hs_in=%0b bus_in=%0h exp 1 3c", hs_in, bus_in); end
    hs_out = 0;
    step();
    checks++; if (hs_in !== 1'b0) begin failures++; $display("FAIL stall_hs_fall got=%0b exp=0", hs_in); end
  endtask

  task automatic test_ack_delay();
    int rise_edge = -1;
    d3_io_rd = 0; d3_bus_out = 8'h11; d3_hs_out = 1;
    // Edge 1 samples the request; hs_in must appear after edge 5.
    for (int e = 1; e <= 7; e++) begin
      step();
      if (rise_edge < 0 && d3_hs_in === 1'b1) rise_edge = e;
    end
    checks++; if (rise_edge != 5) begin failures++; $display("FAIL ack_delay_edge got=%0d exp=5", rise_edge); end
    checks++; if (d3_rx_data !== 8'h11 || d3_rx_count !== 3'd1) begin failures++; $display("FAIL ack_delay_rx got data=%0h count=%0d exp 11 1", d3_rx_data, d3_rx_count); end
    d3_hs_out = 0;
    step();
    checks++; if (d3_hs_in !== 1'b0) begin failures++; $display("FAIL ack_delay_fall got=%0b exp=0", d3_hs_in); end
  endtask

  task automatic test_rx_backpressure();
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    for (int i = 1; i <= 4; i++) do_write(8'(i));
    checks++; if (rx_count !== 3'd4) begin failures++; $display("FAIL bp_count4 got=%0d exp=4", rx_count); end
    io_rd = 0; bus_out = 8'h05; hs_out = 1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (hs_in !== 1'b0 || rx_count !== 3'd4 || rx_data !== 8'h01) begin failures++; $display("FAIL bp_stall got hs_in=%0b count=%0d data=%0h exp 0 4 01", hs_in, rx_count, rx_data); end
    rx_rd = 1;
    step();
    rx_rd = 0;
    step();
    checks++; if (hs_in !== 1'b1 || rx_data !== 8'h02 || rx_count !== 3'd4) begin failures++; $display("FAIL bp_resume got hs_in=%0b data=%0h count=%0d exp 1 02 4", hs_in, rx_data, rx_count); end
    hs_out = 0;
    step();
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (rx_data !== exp_b) begin failures++; $display("FAIL bp_drain got=%0h exp=%0h", rx_data, exp_b); end
      rx_rd = 1;
      step();
      rx_rd = 0;
    end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL bp_empty got=%0b exp=1", rx_empty); end
  endtask

  task automatic test_abort();
    io_rd = 1; hs_out = 1;
    step();
    hs_out = 0;
    step();
    checks++; if (dbg_state !== S_IDLE || hs_in !== 1'b0) begin failures++; $display("FAIL abort_idle got state=%0d hs_in=%0b exp 0 0", dbg_state, hs_in); end
    push_tx(8'h77);
    step();
    checks++; if (bus_in !== 8'h3C) begin failures++; $display("FAIL abort_bus_hold got=%0h exp=3c", bus_in); end
    io_rd = 1; hs_out = 1;
    step(); step();
    checks++; if (hs_in !== 1'b1 || bus_in !== 8'h77) begin failures++; $display("FAIL abort_queued got hs_in=%0b bus_in=%0h exp 1 77", hs_in, bus_in); end
    hs_out = 0;
    step();
  endtask

  task automatic test_reset_mid_ack();
    do_write(8'hAA);
    for (int i = 0; i < 4; i++) push_tx(8'h40 + 8'(i));
    checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0b exp=1", tx_full); end
    push_tx(8'h99);
    checks++; if (tx_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", tx_ovf); end
    io_rd = 1; hs_out = 1;
    step(); step();
    checks++; if (hs_in !== 1'b1 || bus_in !== 8'h40 || dbg_state !== S_ACK) begin failures++; $display("FAIL mid_ack got hs_in=%0b bus_in=%0h state=%0d exp 1 40 2", hs_in, bus_in, dbg_state); end
    push_tx(8'h55);
    checks++; if (tx_full !== 1'b1 || rx_count !== 3'd1) begin failures++; $display("FAIL mid_ack_pre got full=%0b count=%0d exp 1 1", tx_full, rx_count); end
    #2 g_clr = 1;
    #1;
    checks++; if (hs_in !== 1'b0 || bus_in !== 8'h00) begin failures++; $display("FAIL clr_async_out got hs_in=%0b bus_in=%0h exp 0 00", hs_in, bus_in); end
    checks++; if (tx_ovf !== 1'b0 || rx_count !== 3'd0 || tx_full !== 1'b0) begin failures++; $display("FAIL clr_async_fifo got ovf=%0b count=%0d full=%0b exp 0 0 0", tx_ovf, rx_count, tx_full); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL clr_async_state got=%0d exp=0", dbg_state); end
    hs_out = 0;
    step();
    g_clr = 0;
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_ack_delay();
    test_rx_backpressure();
    test_abort();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
